// File: rtl/l1_servo_pkg.sv
// Shared types and target address map for the L1 threshold servo.
package l1_servo_pkg;

  typedef logic [17:0] thresh_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_POLL,
    ST_RD_CNT,
    ST_CALC,
    ST_WR_THR,
    ST_WR_LOAD,
    ST_UPDATE,
    ST_DONE
  } servo_state_t;

  localparam logic [21:0] ADR_CTRL        = 22'h000;
  localparam logic [21:0] ADR_DATA_BASE   = 22'h400;
  localparam logic [21:0] ADR_LOAD_BASE   = 22'h800;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_UPDATE_BIT = 1;
  localparam int CTRL_DONE_BIT   = 0;

endpackage

// File: rtl/l1_servo_step.sv
// One servo step: nudge a beam threshold toward the target rate, clamped to [min, max].
module l1_servo_step
  import l1_servo_pkg::*;
(
  input  logic [31:0] count,
  input  logic [31:0] target,
  input  logic [31:0] tol,
  input  thresh_t     thr,
  input  thresh_t     step,
  input  thresh_t     thr_min,
  input  thresh_t     thr_max,
  output thresh_t     thr_new
);

  logic [32:0]        band_hi;
  logic [32:0]        cnt_lo;
  logic [18:0]        thr_up;
  logic signed [18:0] thr_dn;

  // Band edges are compared in 33 bits so target + tol cannot wrap.
  always_comb begin
    band_hi = {1'b0, target} + {1'b0, tol};
    cnt_lo  = {1'b0, count} + {1'b0, tol};
    thr_up  = {1'b0, thr} + {1'b0, step};
    thr_dn  = $signed({1'b0, thr}) - $signed({1'b0, step});
    thr_new = thr;
    if ({1'b0, count} > band_hi) begin
      thr_new = (thr_up > {1'b0, thr_max}) ? thr_max : thr_up[17:0];
    end else if (cnt_lo < {1'b0, target}) begin
      thr_new = (thr_dn < $signed({1'b0, thr_min})) ? thr_min : thr_dn[17:0];
    end
  end

endmodule

// File: rtl/l1_threshold_servo.sv
// Wishbone host closing the loop on L1 beam trigger thresholds.
// Define L1_SERVO_TIMEOUT_EN to abort any transfer left unacknowledged for ACK_TIMEOUT cycles.
module l1_threshold_servo
  import l1_servo_pkg::*;
#(
  parameter int unsigned NBEAMS        = 2,
  parameter int unsigned POLL_INTERVAL = 1024,
  parameter int unsigned ACK_TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        enable_i,
  input  logic        load_init_i,
  input  logic [17:0] init_thresh_i,
  input  logic [31:0] target_count_i,
  input  logic [31:0] tolerance_i,
  input  logic [17:0] step_i,
  input  logic [17:0] thresh_min_i,
  input  logic [17:0] thresh_max_i,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [21:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        busy_o,
  output logic        iter_done_o,
  output logic        error_o,
  output logic [15:0] iter_count_o
);

  localparam int BW = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;

  servo_state_t state_q, state_d;
  logic         req_q, req_d;
  logic [BW-1:0] beam_q;
  logic [31:0]  wait_cnt;
  logic [31:0]  cnt_q;
  logic         error_q;
  logic [15:0]  iter_cnt_q;
  thresh_t      thr_q [NBEAMS];
  thresh_t      thr_cur;
  thresh_t      thr_new;
  logic [21:0]  beam_ofs;
  logic         xfer_ok;
  logic         bus_fault;
  logic         tmo_hit;

  assign thr_cur  = thr_q[beam_q];
  assign beam_ofs = 22'(beam_q) << 2;
  assign xfer_ok  = req_q && m_ack_i && !m_err_i;
  assign bus_fault = req_q && (m_err_i || tmo_hit);

  l1_servo_step u_step (
    .count   (cnt_q),
    .target  (target_count_i),
    .tol     (tolerance_i),
    .thr     (thr_cur),
    .step    (step_i),
    .thr_min (thresh_min_i),
    .thr_max (thresh_max_i),
    .thr_new (thr_new)
  );

`ifdef L1_SERVO_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tmo_cnt <= '0;
    end else if (!req_q) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign tmo_hit = req_q && (tmo_cnt == 32'(ACK_TIMEOUT - 1));
`else
  // Without the timeout the host waits on ack forever; the parameter stays for a uniform interface.
  assign tmo_hit = 1'b0 && (ACK_TIMEOUT != 0);
`endif

  // Each bus state spends one cycle with the bus idle, then holds cyc/stb until a response.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i && !error_q) state_d = ST_START;
      end
      ST_START, ST_POLL, ST_RD_CNT, ST_WR_THR, ST_WR_LOAD, ST_UPDATE: begin
        if (!req_q) begin
          req_d = 1'b1;
        end else if (xfer_ok) begin
          req_d = 1'b0;
          unique case (state_q)
            ST_START:   state_d = ST_WAIT;
            ST_POLL:    state_d = m_dat_i[CTRL_DONE_BIT] ? ST_RD_CNT : ST_WAIT;
            ST_RD_CNT:  state_d = ST_CALC;
            ST_WR_THR:  state_d = ST_WR_LOAD;
            ST_WR_LOAD: state_d = (beam_q == BW'(NBEAMS - 1)) ? ST_UPDATE : ST_RD_CNT;
            default:    state_d = ST_DONE;
          endcase
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 32'(POLL_INTERVAL - 1)) state_d = ST_POLL;
      end
      ST_CALC: state_d = ST_WR_THR;
      ST_DONE: state_d = enable_i ? ST_START : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus_fault) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      beam_q     <= '0;
      wait_cnt   <= '0;
      cnt_q      <= '0;
      error_q    <= 1'b0;
      iter_cnt_q <= '0;
      for (int i = 0; i < NBEAMS; i++) thr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      if (state_q == ST_WAIT) wait_cnt <= wait_cnt + 32'd1;
      else wait_cnt <= '0;
      if (state_q == ST_RD_CNT && xfer_ok) cnt_q <= m_dat_i;
      if (state_q == ST_POLL && state_d == ST_RD_CNT) beam_q <= '0;
      else if (state_q == ST_WR_LOAD && state_d == ST_RD_CNT) beam_q <= beam_q + BW'(1);
      if (state_q == ST_CALC) thr_q[beam_q] <= thr_new;
      if (bus_fault) begin
        error_q <= 1'b1;
      end else if (state_q == ST_IDLE && load_init_i) begin
        error_q <= 1'b0;
        for (int i = 0; i < NBEAMS; i++) thr_q[i] <= init_thresh_i;
      end
      if (state_q == ST_DONE) iter_cnt_q <= iter_cnt_q + 16'd1;
    end
  end

  // Bus fields derive from the state and beam index, both frozen while stb is high.
  always_comb begin
    m_cyc_o = req_q;
    m_stb_o = req_q;
    m_we_o  = 1'b0;
    m_adr_o = '0;
    m_dat_o = '0;
    m_sel_o = '0;
    if (req_q) begin
      unique case (state_q)
        ST_START: begin
          m_we_o  = 1'b1;
          m_adr_o = ADR_CTRL;
          m_dat_o = 32'(1) << CTRL_START_BIT;
          m_sel_o = 4'b0001;
        end
        ST_POLL: begin
          m_adr_o = ADR_CTRL;
          m_sel_o = 4'b1111;
        end
        ST_RD_CNT: begin
          m_adr_o = ADR_DATA_BASE + beam_ofs;
          m_sel_o = 4'b1111;
        end
        ST_WR_THR: begin
          m_we_o  = 1'b1;
          m_adr_o = ADR_DATA_BASE + beam_ofs;
          m_dat_o = {14'b0, thr_cur};
          m_sel_o = 4'b0111;
        end
        ST_WR_LOAD: begin
          m_we_o  = 1'b1;
          m_adr_o = ADR_LOAD_BASE + beam_ofs;
          m_dat_o = 32'd1;
          m_sel_o = 4'b0010;
        end
        ST_UPDATE: begin
          m_we_o  = 1'b1;
          m_adr_o = ADR_CTRL;
          m_dat_o = 32'(1) << CTRL_UPDATE_BIT;
          m_sel_o = 4'b0010;
        end
        default: ;
      endcase
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign iter_done_o  = (state_q == ST_DONE);
  assign error_o      = error_q;
  assign iter_count_o = iter_cnt_q;

endmodule

// File: tb/tb_l1_threshold_servo.sv
// Directed bench for l1_threshold_servo with a small Wishbone target model.
module tb_l1_threshold_servo;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i = 1'b0;
  logic        enable_i = 1'b0;
  logic        load_init_i = 1'b0;
  logic [17:0] init_thresh_i = '0;
  logic [31:0] target_count_i = 32'd100;
  logic [31:0] tolerance_i = 32'd20;
  logic [17:0] step_i = 18'd10;
  logic [17:0] thresh_min_i = 18'd0;
  logic [17:0] thresh_max_i = 18'd262143;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [21:0] m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0;
  logic        m_err_i = 1'b0;
  logic        busy_o, iter_done_o, error_o;
  logic [15:0] iter_count_o;

  int checks = 0;
  int failures = 0;

  // Target model configuration, written only by the stimulus block.
  logic [31:0] cnt_tab [2];
  int          poll_target = 0;
  int          err_rd_idx = -1;
  logic        hold_all = 1'b0;
  logic        hold_thr = 1'b0;

  // Target model state, written only by the target model.
  int          cyc_n = 0;
  int          poll_num = 0;
  int          rd_idx = 0;
  int          done_pulses = 0;
  int          poll_cyc[$];
  int          cnt_cyc[$];
  logic [57:0] wlog[$];

  l1_threshold_servo #(.NBEAMS(2), .POLL_INTERVAL(8), .ACK_TIMEOUT(255)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .enable_i(enable_i), .load_init_i(load_init_i),
    .init_thresh_i(init_thresh_i), .target_count_i(target_count_i), .tolerance_i(tolerance_i),
    .step_i(step_i), .thresh_min_i(thresh_min_i), .thresh_max_i(thresh_max_i),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o), .m_dat_o(m_dat_o),
    .m_sel_o(m_sel_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
    .busy_o(busy_o), .iter_done_o(iter_done_o), .error_o(error_o), .iter_count_o(iter_count_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(posedge wb_clk_i) begin
    cyc_n <= cyc_n + 1;
    if (iter_done_o) done_pulses <= done_pulses + 1;
  end

  // Single-cycle-latency target: responds once per strobe unless told to hold.
  always @(posedge wb_clk_i) begin
    m_ack_i <= 1'b0;
    m_err_i <= 1'b0;
    if (wb_rst_n_i && m_cyc_o && m_stb_o && !m_ack_i && !m_err_i) begin
      if (hold_all || (hold_thr && m_we_o && m_adr_o == 22'h400)) begin
      end else if (m_we_o) begin
        wlog.push_back({m_adr_o, m_dat_o, m_sel_o});
        m_ack_i <= 1'b1;
      end else if (m_adr_o == 22'h000) begin
        poll_cyc.push_back(cyc_n);
        m_dat_i <= (poll_num >= poll_target) ? 32'd1 : 32'd0;
        poll_num = poll_num + 1;
        m_ack_i <= 1'b1;
      end else begin
        cnt_cyc.push_back(cyc_n);
        m_dat_i <= cnt_tab[m_adr_o[2]];
        if (rd_idx == err_rd_idx) m_err_i <= 1'b1;
        else m_ack_i <= 1'b1;
        rd_idx = rd_idx + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] wr(input logic [21:0] a, input logic [31:0] d, input logic [3:0] s);
    return {6'b0, a, d, s};
  endfunction

  task automatic applyStimulus(input logic [31:0] c0, input logic [31:0] c1);
    cnt_tab[0] = c0;
    cnt_tab[1] = c1;
  endtask

  task automatic loadInit(input logic [17:0] v);
    @(negedge wb_clk_i);
    init_thresh_i = v;
    load_init_i = 1'b1;
    @(negedge wb_clk_i);
    load_init_i = 1'b0;
  endtask

  task automatic runIteration(input string tag);
    int n;
    n = 0;
    enable_i = 1'b1;
    while (!busy_o && n < 50) begin @(negedge wb_clk_i); n++; end
    enable_i = 1'b0;
    checkOutput({tag, "_started"}, 64'(n < 50), 64'd1);
    n = 0;
    while (busy_o && n < 3000) begin @(negedge wb_clk_i); n++; end
    checkOutput({tag, "_finished"}, 64'(n < 3000), 64'd1);
  endtask

  initial begin
    int wb, db, pb, cb, n, minsp;
    logic seen_busy;
    applyStimulus(32'd500, 32'd10);

    repeat (3) @(negedge wb_clk_i);
    checkOutput("reset_ctl", {58'b0, m_cyc_o, m_stb_o, m_we_o, busy_o, iter_done_o, error_o}, 64'd0);
    checkOutput("reset_bus", {6'b0, m_adr_o, m_dat_o, m_sel_o}, 64'd0);
    checkOutput("reset_iter_count", 64'(iter_count_o), 64'd0);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);

    // Basic iteration: counts {500, 10} around target 100 +/- 20.
    loadInit(18'd1000);
    wb = wlog.size(); db = done_pulses;
    runIteration("basic");
    checkOutput("basic_nwrites", 64'(wlog.size() - wb), 64'd6);
    checkOutput("basic_start", {6'b0, wlog[wb]},   wr(22'h000, 32'd1, 4'b0001));
    checkOutput("basic_thr0",  {6'b0, wlog[wb+1]}, wr(22'h400, 32'd1010, 4'b0111));
    checkOutput("basic_load0", {6'b0, wlog[wb+2]}, wr(22'h800, 32'd1, 4'b0010));
    checkOutput("basic_thr1",  {6'b0, wlog[wb+3]}, wr(22'h404, 32'd990, 4'b0111));
    checkOutput("basic_load1", {6'b0, wlog[wb+4]}, wr(22'h804, 32'd1, 4'b0010));
    checkOutput("basic_update", {6'b0, wlog[wb+5]}, wr(22'h000, 32'd2, 4'b0010));
    checkOutput("basic_done_pulses", 64'(done_pulses - db), 64'd1);
    checkOutput("basic_iter_count", 64'(iter_count_o), 64'd1);

    // Band edges: 120 and 80 are in band; 121 and 79 are just outside.
    applyStimulus(32'd120, 32'd80);
    wb = wlog.size();
    runIteration("edge_in");
    checkOutput("edge_hi_unchanged", {6'b0, wlog[wb+1]}, wr(22'h400, 32'd1010, 4'b0111));
    checkOutput("edge_lo_unchanged", {6'b0, wlog[wb+3]}, wr(22'h404, 32'd990, 4'b0111));
    applyStimulus(32'd121, 32'd79);
    wb = wlog.size();
    runIteration("edge_out");
    checkOutput("edge_hi_up", {6'b0, wlog[wb+1]}, wr(22'h400, 32'd1020, 4'b0111));
    checkOutput("edge_lo_down", {6'b0, wlog[wb+3]}, wr(22'h404, 32'd980, 4'b0111));
    checkOutput("edge_iter_count", 64'(iter_count_o), 64'd3);

    // Clamps at both ends of the range.
    loadInit(18'd5);
    applyStimulus(32'd0, 32'd0);
    wb = wlog.size();
    runIteration("clamp_min");
    checkOutput("clamp_min_b0", {6'b0, wlog[wb+1]}, wr(22'h400, 32'd0, 4'b0111));
    checkOutput("clamp_min_b1", {6'b0, wlog[wb+3]}, wr(22'h404, 32'd0, 4'b0111));
    loadInit(18'd260000);
    step_i = 18'd5000;
    applyStimulus(32'd500, 32'd500);
    wb = wlog.size();
    runIteration("clamp_max");
    checkOutput("clamp_max_b0", {6'b0, wlog[wb+1]}, wr(22'h400, 32'd262143, 4'b0111));
    checkOutput("clamp_max_b1", {6'b0, wlog[wb+3]}, wr(22'h404, 32'd262143, 4'b0111));

    // Polling: three not-done replies before the count completes.
    applyStimulus(32'd100, 32'd100);
    poll_target = poll_num + 3;
    pb = poll_cyc.size(); cb = cnt_cyc.size(); wb = wlog.size();
    runIteration("poll");
    checkOutput("poll_reads", 64'(poll_cyc.size() - pb), 64'd4);
    minsp = 1000000;
    for (int i = pb + 1; i < poll_cyc.size(); i++)
      if (poll_cyc[i] - poll_cyc[i-1] < minsp) minsp = poll_cyc[i] - poll_cyc[i-1];
    checkOutput("poll_spacing", 64'(minsp >= 8), 64'd1);
    checkOutput("poll_then_count", 64'(cnt_cyc[cb] > poll_cyc[poll_cyc.size()-1]), 64'd1);
    checkOutput("poll_thr_inband", {6'b0, wlog[wb+1]}, wr(22'h400, 32'd262143, 4'b0111));
    checkOutput("poll_iter_count", 64'(iter_count_o), 64'd6);

    // Bus error on the second count read of an iteration.
    step_i = 18'd10;
    loadInit(18'd1000);
    applyStimulus(32'd500, 32'd500);
    err_rd_idx = rd_idx + 1;
    wb = wlog.size();
    enable_i = 1'b1;
    n = 0;
    while (!m_err_i && n < 3000) begin @(negedge wb_clk_i); n++; end
    checkOutput("err_seen", 64'(n < 3000), 64'd1);
    @(negedge wb_clk_i);
    checkOutput("err_bus_idle", {61'b0, m_cyc_o, m_stb_o, busy_o}, 64'd0);
    checkOutput("err_flag", 64'(error_o), 64'd1);
    checkOutput("err_nwrites", 64'(wlog.size() - wb), 64'd3);
    checkOutput("err_thr0", {6'b0, wlog[wb+1]}, wr(22'h400, 32'd1010, 4'b0111));
    checkOutput("err_last_load0", {6'b0, wlog[wb+2]}, wr(22'h800, 32'd1, 4'b0010));
    seen_busy = 1'b0;
    repeat (20) begin @(negedge wb_clk_i); if (busy_o || m_cyc_o) seen_busy = 1'b1; end
    checkOutput("err_restart_blocked", 64'(seen_busy), 64'd0);
    checkOutput("err_no_more_writes", 64'(wlog.size() - wb), 64'd3);
    loadInit(18'd1000);
    checkOutput("err_cleared", 64'(error_o), 64'd0);
    wb = wlog.size();
    runIteration("err_restart");
    checkOutput("err_restart_thr0", {6'b0, wlog[wb+1]}, wr(22'h400, 32'd1010, 4'b0111));
    checkOutput("err_restart_update", {6'b0, wlog[wb+5]}, wr(22'h000, 32'd2, 4'b0010));
    checkOutput("err_restart_iter_count", 64'(iter_count_o), 64'd7);

    // Asynchronous reset while a threshold write is stalled on the bus.
    hold_thr = 1'b1;
    enable_i = 1'b1;
    n = 0;
    while (!(m_cyc_o && m_we_o && m_adr_o == 22'h400) && n < 3000) begin @(negedge wb_clk_i); n++; end
    enable_i = 1'b0;
    checkOutput("rst_wr_thr_seen", 64'(n < 3000), 64'd1);
    repeat (3) @(negedge wb_clk_i);
    #2 wb_rst_n_i = 1'b0;
    #1;
    checkOutput("rst_async_ctl", {58'b0, m_cyc_o, m_stb_o, m_we_o, busy_o, iter_done_o, error_o}, 64'd0);
    checkOutput("rst_async_bus", {6'b0, m_adr_o, m_dat_o, m_sel_o}, 64'd0);
    checkOutput("rst_async_iter_count", 64'(iter_count_o), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    hold_thr = 1'b0;
    @(negedge wb_clk_i);

    // Withheld ack on the START write.
    hold_all = 1'b1;
    enable_i = 1'b1;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    enable_i = 1'b0;
    repeat (300) @(negedge wb_clk_i);
`ifdef L1_SERVO_TIMEOUT_EN
    checkOutput("tmo_error", 64'(error_o), 64'd1);
    checkOutput("tmo_bus_idle", {62'b0, m_cyc_o, busy_o}, 64'd0);
`else
    checkOutput("noto_error", 64'(error_o), 64'd0);
    checkOutput("noto_still_waiting", {62'b0, m_cyc_o, busy_o}, 64'd3);
`endif
    hold_all = 1'b0;
    n = 0;
    while (busy_o && n < 3000) begin @(negedge wb_clk_i); n++; end
    checkOutput("final_idle", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
